// File: rtl/internal_memory_pkg.sv
// Shared definitions for the dual-channel internal memory: controller state
// encoding, channel count and a channel-to-onehot helper.
package internal_memory_pkg;

   localparam int NUM_CHANNELS = 2;

   // INIT runs the optional zero-fill; RUN serves requests.
   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Per-channel strobe for a one-bit channel index.
   function automatic logic [NUM_CHANNELS-1:0] chan_onehot(input logic ch);
      return ch ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/internal_memory_dual_rr_arbiter2.sv
// Two-requester round-robin arbiter. The pointer names the channel that wins
// a tie; it moves to the other channel whenever a grant is issued (grants are
// only issued to requesters, so every grant is an accepted request).
module rr_arbiter2
   import internal_memory_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic [NUM_CHANNELS-1:0] request,
   output logic [NUM_CHANNELS-1:0] grant
);

   logic prio;  // 0: channel 0 wins a tie, 1: channel 1 wins a tie

   // Grant the lone requester, or the pointed-at channel on a tie.
   always_comb begin
      grant = '0;
      if (enable) begin
         case (request)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = '0;
         endcase
      end
   end

   // After a grant, the channel that was not granted gets priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= 1'b0;
      end else if (|grant) begin
         prio <= grant[0];
      end
   end

endmodule

// File: rtl/internal_memory_dual.sv
// Dual-channel single-port memory with round-robin arbitration, byte-masked
// (active-low BE) writes and a two-cycle pipelined read path shared by both
// channels.
//
// Handshake: a channel's request is taken on a rising edge where ACT and NEXT
// are both high; while NEXT is low the requester holds ACT/CMD/ADDR/BE/DI/TI.
// NEXT is combinational from ACT and the arbiter pointer. Reads return on
// DO/TO with a one-cycle DRDY strobe for the requesting channel, after the
// second edge following acceptance; writes never raise DRDY.
//
// Optional build macro INTERNAL_MEMORY_DUAL_ZERO_INIT_EN: after reset release
// the controller sits in INIT for 2^AddrWidth cycles writing zero to every
// word, then enters RUN. Without it the controller is always in RUN and RAM
// contents start undefined.
module internal_memory_dual
   import internal_memory_pkg::*;
#(
   parameter int AddrWidth = 16,
   parameter int DataBytes = 8,
   parameter int TagWidth  = 21
) (
   input  logic                                      CLK,
   input  logic                                      RESET,
   input  logic [NUM_CHANNELS-1:0]                   ACT,
   input  logic [NUM_CHANNELS-1:0]                   CMD,
   input  logic [NUM_CHANNELS-1:0][AddrWidth-1:0]    ADDR,
   input  logic [NUM_CHANNELS-1:0][DataBytes-1:0]    BE,
   input  logic [NUM_CHANNELS-1:0][8*DataBytes-1:0]  DI,
   input  logic [NUM_CHANNELS-1:0][TagWidth-1:0]     TI,
   output logic [NUM_CHANNELS-1:0]                   NEXT,
   output logic [NUM_CHANNELS-1:0]                   DRDY,
   output logic [8*DataBytes-1:0]                    DO,
   output logic [TagWidth-1:0]                       TO
);

   localparam int DataWidth = 8 * DataBytes;
   localparam int Depth     = 2 ** AddrWidth;

   state_t state;

`ifdef INTERNAL_MEMORY_DUAL_ZERO_INIT_EN
   logic [AddrWidth-1:0] fill_addr;

   // Controller FSM: sweep every address once in INIT, then stay in RUN.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= ST_INIT;
         fill_addr <= '0;
      end else if (state == ST_INIT) begin
         fill_addr <= fill_addr + 1'b1;
         if (fill_addr == '1) begin
            state <= ST_RUN;
         end
      end
   end
`else
   assign state = ST_RUN;
`endif

   // Arbitration and the winning request.
   logic [NUM_CHANNELS-1:0] grant;
   logic                    sel;
   logic                    accept;
   logic                    req_cmd;
   logic [AddrWidth-1:0]    req_addr;
   logic [DataBytes-1:0]    req_be;
   logic [DataWidth-1:0]    req_di;
   logic [TagWidth-1:0]     req_ti;

   rr_arbiter2 u_arb (
      .clk     (CLK),
      .rst_n   (RESET),
      .enable  (state == ST_RUN),
      .request (ACT),
      .grant   (grant)
   );

   assign NEXT     = grant;
   assign sel      = grant[1];
   assign accept   = |grant;
   assign req_cmd  = CMD[sel];
   assign req_addr = ADDR[sel];
   assign req_be   = BE[sel];
   assign req_di   = DI[sel];
   assign req_ti   = TI[sel];

   // RAM write port: the zero-fill sweep or an accepted channel write.
   logic                 wr_en;
   logic [AddrWidth-1:0] wr_addr;
   logic [DataWidth-1:0] wr_data;
   logic [DataBytes-1:0] wr_mask;  // active-high lane enables

   // Select the write source and turn active-low BE into lane enables.
   always_comb begin
      wr_en   = accept & ~req_cmd;
      wr_addr = req_addr;
      wr_data = req_di;
      wr_mask = ~req_be;
`ifdef INTERNAL_MEMORY_DUAL_ZERO_INIT_EN
      if (state == ST_INIT) begin
         wr_en   = 1'b1;
         wr_addr = fill_addr;
         wr_data = '0;
         wr_mask = '1;
      end
`endif
   end

   // Storage is deliberately not reset; only the fill sweep clears it.
   logic [DataWidth-1:0] mem [Depth];

   // Byte-lane write into the RAM.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         for (int i = 0; i < DataBytes; i++) begin
            if (wr_mask[i]) begin
               mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   // Read pipeline stage 1: capture an accepted read.
   logic                 p1_valid;
   logic                 p1_ch;
   logic [TagWidth-1:0]  p1_tag;
   logic [AddrWidth-1:0] p1_addr;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         p1_valid <= 1'b0;
         p1_ch    <= 1'b0;
         p1_tag   <= '0;
         p1_addr  <= '0;
      end else begin
         p1_valid <= accept & req_cmd;
         p1_ch    <= sel;
         p1_tag   <= req_ti;
         p1_addr  <= req_addr;
      end
   end

   // Read pipeline stage 2: control. A read is taken one edge after any
   // earlier write has landed, so it always sees that write.
   logic                 p2_valid;
   logic                 p2_ch;
   logic [TagWidth-1:0]  p2_tag;
   logic [DataWidth-1:0] p2_data;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         p2_valid <= 1'b0;
         p2_ch    <= 1'b0;
         p2_tag   <= '0;
      end else begin
         p2_valid <= p1_valid;
         p2_ch    <= p1_ch;
         p2_tag   <= p1_tag;
      end
   end

   // Read pipeline stage 2: synchronous RAM read, no reset on the data path.
   always_ff @(posedge CLK) begin
      p2_data <= mem[p1_addr];
   end

   // Output stage: strobe the owning channel; DO/TO hold between returns.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         DRDY <= '0;
         DO   <= '0;
         TO   <= '0;
      end else begin
         DRDY <= p2_valid ? chan_onehot(p2_ch) : '0;
         if (p2_valid) begin
            DO <= p2_data;
            TO <= p2_tag;
         end
      end
   end

endmodule

// File: tb/tb_internal_memory_dual.sv
// Directed bench for internal_memory_dual: hand-computed read data, tags,
// grant order and latency, with a scoreboard queue of expected read returns.
module tb_internal_memory_dual;

`ifdef INTERNAL_MEMORY_DUAL_ZERO_INIT_EN
   localparam int AW          = 4;
   localparam int INIT_CYCLES = 16;
   localparam int ADR_A       = 'h3;
   localparam int ADR_B       = 'h5;
`else
   localparam int AW          = 16;
   localparam int INIT_CYCLES = 0;
   localparam int ADR_A       = 'h0010;
   localparam int ADR_B       = 'h0020;
`endif
   localparam int DB = 8;
   localparam int DW = 64;
   localparam int TW = 21;
   localparam int EW = 32 + 1 + TW + DW;  // {due, ch, tag, data}

   // Clock / reset and DUT signals
   logic                   CLK;
   logic                   RESET;
   logic [1:0]             ACT;
   logic [1:0]             CMD;
   logic [1:0][AW-1:0]     ADDR;
   logic [1:0][DB-1:0]     BE;
   logic [1:0][DW-1:0]     DI;
   logic [1:0][TW-1:0]     TI;
   logic [1:0]             NEXT;
   logic [1:0]             DRDY;
   logic [DW-1:0]          DO;
   logic [TW-1:0]          TO;

   internal_memory_dual #(
      .AddrWidth (AW),
      .DataBytes (DB),
      .TagWidth  (TW)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .ACT   (ACT),
      .CMD   (CMD),
      .ADDR  (ADDR),
      .BE    (BE),
      .DI    (DI),
      .TI    (TI),
      .NEXT  (NEXT),
      .DRDY  (DRDY),
      .DO    (DO),
      .TO    (TO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard of expected read returns
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;

   function automatic logic [EW-1:0] pack_exp(input int due, input logic ch,
                                               input logic [TW-1:0] tag, input logic [DW-1:0] data);
      return {32'(due), ch, tag, data};
   endfunction

   // Compare every DRDY against the head of the queue; flag late/missing ones.
   always @(negedge CLK) begin
      if (RESET === 1'b1) begin
         if (DRDY != 2'b00) begin
            check("drdy_onehot", 64'($countones(DRDY)), 64'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_drdy", {62'b0, DRDY}, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("drdy_latency", 64'(cyc), 64'(mon_e[EW-1 -: 32]));
               check("drdy_chan", {62'b0, DRDY}, mon_e[DW+TW] ? 64'd2 : 64'd1);
               check("rsp_tag", 64'(TO), 64'(mon_e[DW +: TW]));
               check("rsp_data", DO, mon_e[DW-1:0]);
            end
         end else if (exp_q.size() != 0) begin
            mon_e = exp_q[0];
            if (int'(mon_e[EW-1 -: 32]) < cyc) begin
               check("missing_drdy", 64'(cyc), 64'(mon_e[EW-1 -: 32]));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // Driver: present one request on channel ch from a falling edge, hold it
   // until granted, then drop it at the next falling edge.
   task automatic do_req(input logic ch, input logic cmd, input int addr,
                         input logic [DB-1:0] be, input logic [DW-1:0] di,
                         input logic [TW-1:0] ti, input logic expect_rsp,
                         input logic [DW-1:0] exp_data);
      int tries = 0;
      bit got = 1'b0;
      ACT[ch]  = 1'b1;
      CMD[ch]  = cmd;
      ADDR[ch] = AW'(addr);
      BE[ch]   = be;
      DI[ch]   = di;
      TI[ch]   = ti;
      #1;
      while (!got && tries < 40) begin
         if (NEXT[ch]) begin
            got = 1'b1;
            if (cmd && expect_rsp) exp_q.push_back(pack_exp(cyc + 3, ch, ti, exp_data));
            @(posedge CLK);
         end else begin
            @(negedge CLK);
            #1;
            tries++;
         end
      end
      if (!got) check("grant_timeout", 64'd0, 64'd1);
      @(negedge CLK);
      ACT[ch] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         @(negedge CLK);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   initial begin
      int stall;
      logic g;
      RESET = 1'b1;
      ACT   = '0;
      CMD   = '0;
      ADDR  = '0;
      BE    = '1;
      DI    = '0;
      TI    = '0;
      #1 RESET = 1'b0;
      #1;
      // asynchronous reset values, before any clock edge
      check("reset_drdy", {62'b0, DRDY}, 64'd0);
      check("reset_do", DO, 64'd0);
      check("reset_to", 64'(TO), 64'd0);
      repeat (2) @(negedge CLK);
      RESET = 1'b1;

      // first request after release: stalls only while zero-filling
      stall   = 0;
      ACT[0]  = 1'b1;
      CMD[0]  = 1'b0;
      ADDR[0] = AW'(ADR_A);
      BE[0]   = 8'h00;
      DI[0]   = 64'h1122334455667788;
      TI[0]   = 21'h1;
      #1;
      while (!NEXT[0] && stall < 100) begin
         @(negedge CLK);
         #1;
         stall++;
      end
      check("init_stall_cycles", 64'(stall), 64'(INIT_CYCLES));
      check("first_grant", {62'b0, NEXT}, 64'd1);
      @(posedge CLK);
      @(negedge CLK);
      ACT[0] = 1'b0;

`ifdef INTERNAL_MEMORY_DUAL_ZERO_INIT_EN
      // untouched word reads back as zero after the fill
      do_req(1'b0, 1'b1, 'h7, 8'hFF, 64'h0, 21'h27, 1'b1, 64'h0);
      drain();
`endif

      // full write then read, latency 2
      do_req(1'b0, 1'b1, ADR_A, 8'hFF, 64'h0, 21'h5, 1'b1, 64'h1122334455667788);
      drain();

      // masked write of the low byte only
      do_req(1'b0, 1'b0, ADR_A, 8'hFE, 64'hFF, 21'h0, 1'b0, 64'h0);
      do_req(1'b0, 1'b1, ADR_A, 8'hFF, 64'h0, 21'h6, 1'b1, 64'h11223344556677FF);
      drain();

      // ch1 write, ch0 reads the same word on the very next cycle
      do_req(1'b1, 1'b0, ADR_B, 8'h00, {8{8'hAA}}, 21'h0, 1'b0, 64'h0);
      do_req(1'b0, 1'b1, ADR_B, 8'hFF, 64'h0, 21'h7, 1'b1, 64'hAAAAAAAAAAAAAAAA);
      // upper four bytes only, then an all-ones BE write that changes nothing
      do_req(1'b1, 1'b0, ADR_B, 8'h0F, 64'h12345678_00000000, 21'h0, 1'b0, 64'h0);
      do_req(1'b0, 1'b1, ADR_B, 8'hFF, 64'h0, 21'h9, 1'b1, 64'h12345678AAAAAAAA);
      do_req(1'b1, 1'b0, ADR_B, 8'hFF, {8{8'h55}}, 21'h0, 1'b0, 64'h0);
      do_req(1'b1, 1'b1, ADR_B, 8'hFF, 64'h0, 21'h8, 1'b1, 64'h12345678AAAAAAAA);
      drain();

      // both channels read continuously; last grant was ch1, so ch0 leads
      ACT     = 2'b11;
      CMD     = 2'b11;
      ADDR[0] = AW'(ADR_A);
      ADDR[1] = AW'(ADR_B);
      BE      = '1;
      TI[0]   = 21'h100;
      TI[1]   = 21'h200;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("grant_seq", {62'b0, NEXT}, (i % 2 == 0) ? 64'd1 : 64'd2);
         g = NEXT[1];
         if (NEXT[0]) exp_q.push_back(pack_exp(cyc + 3, 1'b0, TI[0], 64'h11223344556677FF));
         else if (NEXT[1]) exp_q.push_back(pack_exp(cyc + 3, 1'b1, TI[1], 64'h12345678AAAAAAAA));
         @(posedge CLK);
         @(negedge CLK);
         if (g) TI[1] = TI[1] + 1'b1;
         else   TI[0] = TI[0] + 1'b1;
      end
      ACT = 2'b00;
      drain();

      // reset one cycle after a read is accepted: the read must vanish
      do_req(1'b0, 1'b1, ADR_A, 8'hFF, 64'h0, 21'h1F, 1'b0, 64'h0);
      @(posedge CLK);
      #1 RESET = 1'b0;
      #1;
      check("midrst_drdy", {62'b0, DRDY}, 64'd0);
      check("midrst_do", DO, 64'd0);
      check("midrst_to", 64'(TO), 64'd0);
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      repeat (6) @(negedge CLK);
      check("postrst_drdy", {62'b0, DRDY}, 64'd0);
      check("postrst_do", DO, 64'd0);
      check("postrst_to", 64'(TO), 64'd0);

      // RAM survives reset unless the fill sweep runs
      do_req(1'b1, 1'b1, ADR_A, 8'hFF, 64'h0, 21'h33, 1'b1,
             (INIT_CYCLES != 0) ? 64'h0 : 64'h11223344556677FF);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
